// File: rtl/book_mem_arbiter.sv
// book_mem_arbiter
//   Round-robin arbiter that lets several order-book engines share a single
//   memory-manager port. It runs exactly one memory operation at a time,
//   holds address and write data stable for the whole operation, captures
//   read data on mem_valid_in, and returns a one-cycle per-requester ack.
//   A watchdog aborts an operation whose valid never arrives.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-high reset
//   req_in[NUM_REQ]         per-requester request level
//   req_is_write_in         per-requester op type (1 = write)
//   req_addr_in / data_in   packed per-requester address / write data
//   ack_out                 one-hot completion pulse
//   err_out                 high with ack_out when the op timed out
//   rdata_out               read data, meaningful while ack_out != 0
//   busy_out                high whenever an operation is in flight
//   mem_start_out           one-cycle start strobe to the memory manager
//   mem_is_write_out, mem_addr_out, mem_data_out   operation to the manager
//   mem_valid_in, mem_data_in                     completion from the manager
//   stray_flag_out          sticky: valid seen while not waiting for one
module book_mem_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ-1:0]        req_is_write_in,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_in,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
  output logic [NUM_REQ-1:0]        ack_out,
  output logic                      err_out,
  output logic [DATA_W-1:0]         rdata_out,
  output logic                      busy_out,
  output logic                      mem_start_out,
  output logic                      mem_is_write_out,
  output logic [ADDR_W-1:0]         mem_addr_out,
  output logic [DATA_W-1:0]         mem_data_out,
  input  logic                      mem_valid_in,
  input  logic [DATA_W-1:0]         mem_data_in,
  output logic                      stray_flag_out
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] r_winner;
  logic [CNT_W-1:0] r_cnt;

  logic             w_found;
  logic [IDX_W-1:0] w_winner;
  logic [IDX_W-1:0] w_idx;

  // Search upward from the requester after the last grant, wrapping, so the
  // most recently served requester is considered last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && req_in[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state          <= S_IDLE;
      r_last           <= LAST_RST;
      r_winner         <= '0;
      r_cnt            <= '0;
      ack_out          <= '0;
      err_out          <= 1'b0;
      rdata_out        <= '0;
      busy_out         <= 1'b0;
      mem_start_out    <= 1'b0;
      mem_is_write_out <= 1'b0;
      mem_addr_out     <= '0;
      mem_data_out     <= '0;
      stray_flag_out   <= 1'b0;
    end else begin
      // A valid outside WAIT belongs to no live operation (late after a
      // timeout, or left over from a reset); record it and otherwise ignore.
      if (mem_valid_in && (r_state != S_WAIT)) begin
        stray_flag_out <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_winner         <= w_winner;
            mem_is_write_out <= req_is_write_in[w_winner];
            mem_addr_out     <= req_addr_in[w_winner*ADDR_W +: ADDR_W];
            mem_data_out     <= req_data_in[w_winner*DATA_W +: DATA_W];
            mem_start_out    <= 1'b1;
            busy_out         <= 1'b1;
            r_state          <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          mem_start_out <= 1'b0;
          r_cnt         <= '0;
          r_state       <= S_WAIT;
        end

        S_WAIT: begin
          // Valid is checked before the limit so a response on the last
          // allowed cycle still completes cleanly.
          if (mem_valid_in) begin
            if (!mem_is_write_out) begin
              rdata_out <= mem_data_in;
            end
            ack_out <= NUM_REQ'(1) << r_winner;
            err_out <= 1'b0;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_MAX) begin
            ack_out <= NUM_REQ'(1) << r_winner;
            err_out <= 1'b1;
            r_state <= S_DONE;
          end else begin
            // Only reached below CNT_MAX, so the counter never wraps.
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          ack_out  <= '0;
          err_out  <= 1'b0;
          busy_out <= 1'b0;
          r_last   <= r_winner;
          r_state  <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
